// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, width helpers and the response control type for mem_pipe.
package mem_pkg;
    localparam int MAX_LATENCY = 4;
    // Data rides beside this struct because its width is a per-instance parameter.
    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } rsp_ctl_t;
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
    function automatic int off_width(input int data_w);
        return (data_w > 8) ? $clog2(data_w / 8) : 0;
    endfunction
endpackage

// File: rtl/mem_delay.sv
// mem_delay: N-stage register chain, every stage cleared by asynchronous reset.
module mem_delay #(
    parameter int N = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r [N];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r <= '{default: '0};
        else begin
            r[0] <= d;
            for (int i = 1; i < N; i++) r[i] <= r[i-1];
        end
    end
    assign q = r[N-1];
endmodule

// File: rtl/mem_pipe.sv
// mem_pipe: single-port pipelined memory with byte-enable writes and error response.
module mem_pipe
  import mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 128,
  parameter int    ADDR_W    = 32,
  parameter int    LATENCY   = 1,
  parameter int    BYTE_ADDR = 0,
  parameter string INIT_FILE = "risc.txt"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                rsp_we
);
  localparam int BYTES = DATA_W / 8;
  localparam int IW    = idx_width(DEPTH);
  localparam int OW    = off_width(DATA_W);
  localparam int SW    = $bits(rsp_ctl_t) + DATA_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] widx;
  logic [IW-1:0]     idx;
  logic              err;
  logic              wr;
  logic [DATA_W-1:0] rdata;
  logic [SW-1:0]     s1;
  logic [SW-1:0]     so;
  rsp_ctl_t          ctl;
  always_comb begin
    widx  = (BYTE_ADDR != 0) ? (req_addr >> OW) : req_addr;
    idx   = widx[IW-1:0];
    err   = ((BYTE_ADDR != 0) && ((req_addr & ADDR_W'(BYTES - 1)) != '0)) || (widx >= ADDR_W'(DEPTH));
    wr    = req_valid && req_we && !err && !rst;
    rdata = (req_valid && !req_we && !err) ? mem[idx] : '0;
  end
  always_ff @(posedge clk) begin
    if (wr)
      for (int b = 0; b < BYTES; b++)
        if (req_be[b]) mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1 <= '0;
    else     s1 <= {req_valid, req_valid && req_we, req_valid && err, rdata};
  end
  if (LATENCY > 1) begin : g_delay
    mem_delay #(.N(LATENCY - 1), .W(SW)) u_delay (
      .clk(clk),
      .rst(rst),
      .d  (s1),
      .q  (so)
    );
  end else begin : g_bypass
    assign so = s1;
  end
  assign {ctl, rsp_data} = so;
  assign rsp_valid = ctl.valid;
  assign rsp_we    = ctl.we;
  assign rsp_err   = ctl.err;
endmodule

// File: tb/tb_mem_pipe.sv
// tb_mem_pipe: four mem_pipe configurations share one request stream; a monitor
// compares every response against queued expectations from a word-array model.
module tb_mem_pipe;
    localparam int NDUT = 4;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 4 : 2;
    endfunction
    function automatic int ba_of(input int k);
        return (k >= 2) ? 1 : 0;
    endfunction

    typedef struct {
        int          cyc;
        logic        we;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rv [NDUT];
    logic        rw [NDUT];
    logic        re [NDUT];
    logic [31:0] rd [NDUT];

    exp_t        q [NDUT][$];
    logic [31:0] mdl [NDUT][128];
    exp_t        cur;
    logic        has;
    logic [31:0] ra;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_pipe #(
            .DATA_W   (32),
            .DEPTH    (128),
            .ADDR_W   (32),
            .LATENCY  (lat_of(g)),
            .BYTE_ADDR(ba_of(g)),
            .INIT_FILE("")
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid),
            .req_we   (req_we),
            .req_addr (req_addr),
            .req_wdata(req_wdata),
            .req_be   (req_be),
            .rsp_valid(rv[g]),
            .rsp_data (rd[g]),
            .rsp_err  (re[g]),
            .rsp_we   (rw[g])
        );
    end

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d (lat=%0d ba=%0d) cyc=%0d: got %h want %h", name, k, lat_of(k), ba_of(k), cyc, act, exp);
        end
    endtask

    task automatic model(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] idx;
        exp_t        e;
        idx    = (ba_of(k) != 0) ? (addr >> 2) : addr;
        e.cyc  = cyc + lat_of(k);
        e.we   = we;
        e.err  = ((ba_of(k) != 0) && (addr[1:0] != 2'b00)) || (idx >= 128);
        e.data = '0;
        if (!e.err && we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[k][idx[6:0]][b*8 +: 8] = wd[b*8 +: 8];
        if (!e.err && !we) e.data = mdl[k][idx[6:0]];
        q[k].push_back(e);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        if (!rst)
            for (int k = 0; k < NDUT; k++) model(k, we, addr, wd, be);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < NDUT; k++) begin
            has = (q[k].size() > 0) && (q[k][0].cyc == cyc);
            check("rsp_valid", k, 64'(rv[k]), 64'(has));
            if (has) begin
                cur = q[k].pop_front();
                if (rv[k]) begin
                    check("rsp_data", k, 64'(rd[k]), 64'(cur.data));
                    check("rsp_err", k, 64'(re[k]), 64'(cur.err));
                    check("rsp_we", k, 64'(rw[k]), 64'(cur.we));
                end
            end
            if (!rv[k]) check("idle_outputs", k, 64'({rw[k], re[k], rd[k]}), 64'd0);
        end
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) issue(1'b1, 32'(i), 32'h1000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 128; i++) issue(1'b1, 32'(4 * i), 32'h2000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 10; i++) issue(1'b0, 32'(i), '0, 4'h0);
        issue(1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 32'd5, '0, 4'h0);
        issue(1'b1, 32'd7, 32'h1122_3344, 4'hF);
        issue(1'b1, 32'd7, 32'hAABB_CCDD, 4'b0101);
        issue(1'b0, 32'd7, '0, 4'h0);
        issue(1'b1, 32'd28, 32'h1122_3344, 4'hF);
        issue(1'b1, 32'd28, 32'hAABB_CCDD, 4'b0101);
        issue(1'b0, 32'd28, '0, 4'h0);
        issue(1'b0, 32'h6, '0, 4'h0);
        issue(1'b1, 32'h200, 32'hCAFE_F00D, 4'hF);
        issue(1'b0, 32'h0, '0, 4'h0);
        issue(1'b1, 32'd3, 32'h5555_5555, 4'h0);
        issue(1'b0, 32'd3, '0, 4'h0);
        issue(1'b0, 32'd127, '0, 4'h0);
        issue(1'b0, 32'd128, '0, 4'h0);
        issue(1'b0, 32'h1FC, '0, 4'h0);
        idle(6);
        issue(1'b0, 32'd1, '0, 4'h0);
        issue(1'b0, 32'd2, '0, 4'h0);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_drop", k, 64'({rv[k], rw[k], re[k], rd[k]}), 64'd0);
            q[k].delete();
        end
        issue(1'b1, 32'd9, 32'hBAD0_BAD0, 4'hF);
        idle(2);
        rst = 1'b0;
        issue(1'b0, 32'd9, '0, 4'h0);
        issue(1'b0, 32'd36, '0, 4'h0);
        idle(6);
        for (int i = 0; i < 100; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 600)) : 32'($urandom_range(0, 140));
            issue(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
        end
        idle(8);
        for (int k = 0; k < NDUT; k++) check("drained", k, 64'(q[k].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
